mux_2x1_24bit: RTL and testbench

- 24-bit two-input multiplexer used in the floating-point datapath to steer mantissa-width operands (24 bits, implicit bit included).
- Primary output X is purely combinational.
- A registered, resettable copy of the selected value and a monitor of select activity are provided for pipelined consumers and debug.

---
 rtl/mux_2x1_24bit.sv | 55 +++++
 tb/tb_mux_2x1_24bit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mux_2x1_24bit.sv
// Two-input mantissa-width multiplexer with a zero-latency combinational output,
// plus a registered copy of the selection and a saturating select-toggle monitor.
module mux_2x1_24bit #(
    parameter int WIDTH     = 24,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 S,
    output logic [WIDTH-1:0]     X,
    output logic [WIDTH-1:0]     X_q,
    output logic                 S_q,
    output logic [CNT_WIDTH-1:0] toggle_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]     x_s;
    logic                 toggle_s;
    logic                 cnt_sat_s;
    logic [WIDTH-1:0]     x_q_r;
    logic                 s_q_r;
    logic [CNT_WIDTH-1:0] cnt_r;

    // Ternary keeps X independent of clk/reset and merges agreeing bits when S is unknown.
    assign x_s       = S ? B : A;
    assign toggle_s  = (S != s_q_r);
    assign cnt_sat_s = (cnt_r == CNT_MAX);

    // Registered selection, select history and saturating toggle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q_r <= {WIDTH{1'b0}};
            s_q_r <= 1'b0;
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            x_q_r <= x_s;
            s_q_r <= S;
            if (toggle_s && !cnt_sat_s) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign X          = x_s;
    assign X_q        = x_q_r;
    assign S_q        = s_q_r;
    assign toggle_cnt = cnt_r;

endmodule

// File: tb/tb_mux_2x1_24bit.sv
// Self-checking bench for mux_2x1_24bit: directed literal checks plus randomized
// stimulus compared every cycle against a behavioural model of the registered path.
module tb_mux_2x1_24bit;

    localparam int WIDTH     = 24;
    localparam int CNT_WIDTH = 16;
    localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

    logic                 clk;
    logic                 reset;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 S;
    logic [WIDTH-1:0]     X;
    logic [WIDTH-1:0]     X_q;
    logic                 S_q;
    logic [CNT_WIDTH-1:0] toggle_cnt;

    int tests = 0;
    int fails = 0;
    bit clk_en   = 1'b0;
    bit check_en = 1'b0;

    // Behavioural model state: last selected word, last select, transitions seen.
    logic [WIDTH-1:0] m_xq;
    logic             m_s;
    int               m_cnt;

    mux_2x1_24bit #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .A          (A),
        .B          (B),
        .S          (S),
        .X          (X),
        .X_q        (X_q),
        .S_q        (S_q),
        .toggle_cnt (toggle_cnt)
    );

    // Clock stays undriven until the combinational checks are done.
    initial begin
        wait (clk_en);
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: registered outputs lag the selection by one clock; counter counts select changes, capped.
    always @(posedge clk or posedge reset) begin
        if (reset === 1'b1) begin
            m_xq  <= '0;
            m_s   <= 1'b0;
            m_cnt <= 0;
        end else begin
            m_xq  <= (S === 1'b1) ? B : A;
            m_s   <= S;
            m_cnt <= (S !== m_s) ? ((m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1) : m_cnt;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            check("x_comb", 32'(X), 32'((S === 1'b1) ? B : A));
            check("x_q", 32'(X_q), 32'(m_xq));
            check("s_q", 32'(S_q), 32'(m_s));
            check("toggle_cnt", 32'(toggle_cnt), 32'(m_cnt));
        end
    end

    initial begin
        // Combinational path with clk and reset never driven.
        A = 24'd1; B = 24'd2; S = 1'b0;
        #10 check("sel_a", 32'(X), 32'd1);
        S = 1'b1;
        #10 check("sel_b", 32'(X), 32'd2);
        S = 1'b0;
        #10 check("back_a", 32'(X), 32'd1);
        A = 24'h000005; B = 24'h000005; S = 1'bx;
        #10 check("s_unknown_agree", 32'(X), 32'h000005);
        A = 24'hFFFFFF; B = 24'h000000;
        for (int i = 0; i < 4; i++) begin
            S = i[0];
            #10 check("full_width", 32'(X), (i % 2 == 0) ? 32'h00FFFFFF : 32'h00000000);
        end

        // Asynchronous reset with no clock running.
        reset = 1'b1;
        #1;
        check("rst_xq", 32'(X_q), 32'd0);
        check("rst_sq", 32'(S_q), 32'd0);
        check("rst_cnt", 32'(toggle_cnt), 32'd0);

        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("rst_hold_xq", 32'(X_q), 32'd0);
        @(negedge clk);
        reset = 1'b0; A = 24'h123456; S = 1'b0;
        @(posedge clk);
        #1;
        check("load_a", 32'(X_q), 32'h00123456);
        check("load_a_cnt", 32'(toggle_cnt), 32'd0);
        S = 1'b1; B = 24'hABCDEF;
        @(posedge clk);
        #1;
        check("load_b", 32'(X_q), 32'h00ABCDEF);
        check("load_b_sq", 32'(S_q), 32'd1);
        check("load_b_cnt", 32'(toggle_cnt), 32'd1);

        // Randomized traffic, checked every cycle by the compare process.
        check_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            A = WIDTH'($urandom);
            B = WIDTH'($urandom);
            S = ($urandom_range(0, 3) == 0) ? S : 1'($urandom);
        end

        // Reset between clock edges while holding ABCDEF.
        @(posedge clk);
        #2;
        B = 24'hABCDEF; S = 1'b1;
        @(posedge clk);
        #1 check("pre_mid_rst", 32'(X_q), 32'h00ABCDEF);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_xq", 32'(X_q), 32'd0);
        check("mid_rst_sq", 32'(S_q), 32'd0);
        check("mid_rst_cnt", 32'(toggle_cnt), 32'd0);
        check("mid_rst_x", 32'(X), 32'h00ABCDEF);
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);

        // Saturation: toggle S on every clock for 2^CNT_WIDTH+5 edges after a fresh reset.
        #2 reset = 1'b1; S = 1'b0;
        @(negedge clk);
        #1 reset = 1'b0; S = 1'b1;
        for (int i = 0; i < (1 << CNT_WIDTH) + 5; i++) begin
            @(posedge clk);
            #2;
            S = ~S;
            A = WIDTH'($urandom);
            B = WIDTH'($urandom);
        end
        #1 check("saturated", 32'(toggle_cnt), 32'h0000FFFF);
        @(negedge clk);
        check_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
